wb_scheduler: RTL and testbench
===============================

Name: wb_scheduler

Overview:
- Write-side front end of the dual-write-port register file: merges two ALU lanes and one load-return stream onto write ports A (waA/WD3/WEA) and B (waB/WD6/WEB).
- ALU lanes can never stall; load results are buffered in an in-order FIFO and drained into whichever ports the ALU lanes leave idle.
- Enforces WAW ordering and drives a pending-register mask to the hazard unit.

Parameters:
- DEPTH, 4: load FIFO entries; power of two, at least 2.
- ADDR_WIDTH, 5: register address width.
- DATA_WIDTH, 32: register data width.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_a_valid  input  1  lane A result valid (older of the two lanes)
- alu_a_rd  input  ADDR_WIDTH  lane A destination
- alu_a_data  input  DATA_WIDTH  lane A result
- alu_b_valid  input  1  lane B result valid (younger)
- alu_b_rd  input  ADDR_WIDTH  lane B destination
- alu_b_data  input  DATA_WIDTH  lane B result
- ld_valid  input  1  load result valid
- ld_rd  input  ADDR_WIDTH  load destination
- ld_data  input  DATA_WIDTH  load data
- ld_ready  output  1  FIFO can accept; transfer on ld_valid & ld_ready
- waA  output  ADDR_WIDTH  port A write address
- WD3  output  DATA_WIDTH  port A write data
- WEA  output  1  port A write enable
- waB  output  ADDR_WIDTH  port B write address
- WD6  output  DATA_WIDTH  port B write data
- WEB  output  1  port B write enable
- pending  output  2**ADDR_WIDTH  bit r set while a live FIFO entry targets register r
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy, dead entries included

Behaviour:
- Reset (async, rst_n low): WEA/WEB=0, waA/waB/WD3/WD6=0, FIFO empty, pending=0, fifo_count=0. ld_ready=1 once rst_n is high.
- All port outputs are registered. A decision made in cycle t appears on the port outputs in cycle t+1.
- Register 0 filter: any request with rd=0 is discarded. An ALU request with rd=0 does not occupy a port. A load with rd=0 is accepted (handshake completes) but is not enqueued.
- Lane effectiveness: lane A is effective if alu_a_valid & rd≠0. Lane B likewise.
  - If both lanes are effective with equal rd, lane A is dropped.
- Port mapping: effective lane A goes to port A; effective lane B goes to port B.
- Kill, applied combinationally before enqueue and drain in the same cycle:
  - Every FIFO entry whose rd equals an effective ALU rd is marked dead.
  - An incoming load whose ld_rd equals an effective ALU rd is accepted but not enqueued (the load is treated as older).
- Drain, evaluated on the entries at head and head+1 in order:
  - A dead entry pops without using a port.
  - A live entry pops only if a port is free. It takes port A if free, otherwise port B.
  - Evaluation stops at the first live entry with no free port.
  - At most two pops per cycle.
- If both popped live entries share an rd, the older one is popped with no write and the younger one takes a port.
- Enqueue: the incoming load writes at the tail in the same cycle as pops. An entry enqueued in cycle t is first drainable in cycle t+1.
- ld_ready = (fifo_count < DEPTH), using registered occupancy. No enqueue is ever attempted when full.
- fifo_count_next = fifo_count + enq - pops, never exceeding DEPTH.
- pending is recomputed from registered FIFO state, live entries only.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by fifo_count.
- Reset mid-operation: FIFO contents are discarded and any registered write in flight is cancelled (WEA/WEB=0 immediately).

Test Plan:
1. Reset, then a single lane A request (x5, 0x11) → next cycle: WEA=1, waA=5, WD3=0x11, WEB=0, ld_ready=1, fifo_count=0.
2. Both lanes target x7 (A=0xAA, B=0xBB) → next cycle: WEA=0, WEB=1, waB=7, WD6=0xBB.
3. With both lanes busy for 5 cycles, loads to x1..x4 arrive → ld_ready drops to 0 after 4 loads, fifo_count=4, pending=0x1E. When lanes go idle: x1 and x2 written on A and B in one cycle, then x3 and x4 the next; pending returns to 0.
4. Load to x9 is enqueued while lanes are busy; later lane A writes x9=0x55 → entry killed, pending[9] clears, x9 is never written with the load data; fifo_count drops as the dead entry pops with no WE.
5. Load to x0 and ALU request to x0 → ld_ready stays 1, fifo_count=0, WEA=WEB=0.
6. rst_n asserted low while fifo_count=3 and WEA=1 → WEA=0, fifo_count=0, pending=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_scheduler.sv
// wb_scheduler: merges two ALU lanes and a buffered load stream onto two register-file write ports,
// enforcing WAW order and exporting a pending-register mask for loads still queued.
module wb_scheduler #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_a_valid,
    input  logic [ADDR_WIDTH-1:0]      alu_a_rd,
    input  logic [DATA_WIDTH-1:0]      alu_a_data,
    input  logic                       alu_b_valid,
    input  logic [ADDR_WIDTH-1:0]      alu_b_rd,
    input  logic [DATA_WIDTH-1:0]      alu_b_data,
    input  logic                       ld_valid,
    input  logic [ADDR_WIDTH-1:0]      ld_rd,
    input  logic [DATA_WIDTH-1:0]      ld_data,
    output logic                       ld_ready,
    output logic [ADDR_WIDTH-1:0]      waA,
    output logic [DATA_WIDTH-1:0]      WD3,
    output logic                       WEA,
    output logic [ADDR_WIDTH-1:0]      waB,
    output logic [DATA_WIDTH-1:0]      WD6,
    output logic                       WEB,
    output logic [2**ADDR_WIDTH-1:0]   pending,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] rd_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      live_q, live_d, live_k;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, h1;
    logic [CW-1:0]         count_q, count_d;
    logic                  wea_q, wea_d, web_q, web_d;
    logic [ADDR_WIDTH-1:0] wa_a_q, wa_a_d, wa_b_q, wa_b_d;
    logic [DATA_WIDTH-1:0] wd_a_q, wd_a_d, wd_b_q, wd_b_d;

    logic                  a_eff, b_eff, a_use, free_a, free_b;
    logic [1:0]            nfree;
    logic                  l0, l1, pop0, pop1, w0, w1, dup, d0, d1;
    logic                  has_first, has_second, enq;
    logic [ADDR_WIDTH-1:0] first_rd;
    logic [DATA_WIDTH-1:0] first_data;

    assign a_eff  = alu_a_valid && alu_a_rd != '0;
    assign b_eff  = alu_b_valid && alu_b_rd != '0;
    // same-destination lanes: the younger lane B wins
    assign a_use  = a_eff && !(b_eff && alu_a_rd == alu_b_rd);
    assign free_a = !a_use;
    assign free_b = !b_eff;
    assign nfree  = {1'b0, free_a} + {1'b0, free_b};

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            live_k[i] = live_q[i] && !(a_eff && rd_q[i] == alu_a_rd) && !(b_eff && rd_q[i] == alu_b_rd);
    end

    assign h1   = head_q + 1'b1;
    assign l0   = live_k[head_q];
    assign l1   = live_k[h1];
    assign pop0 = count_q != '0 && (!l0 || nfree != 2'd0);
    assign pop1 = pop0 && count_q > CW'(1) && (!l1 || nfree > {1'b0, l0});
    assign w0   = pop0 && l0;
    assign w1   = pop1 && l1;
    // two queued writes to one register: only the younger reaches the file
    assign dup  = w0 && w1 && rd_q[head_q] == rd_q[h1];
    assign d0   = w0 && !dup;
    assign d1   = w1;
    assign has_first  = d0 || d1;
    assign has_second = d0 && d1;
    assign first_rd   = d0 ? rd_q[head_q] : rd_q[h1];
    assign first_data = d0 ? data_q[head_q] : data_q[h1];

    assign wea_d  = a_use || (free_a && has_first);
    assign wa_a_d = a_use ? alu_a_rd : first_rd;
    assign wd_a_d = a_use ? alu_a_data : first_data;
    assign web_d  = b_eff || (free_a ? has_second : has_first);
    assign wa_b_d = b_eff ? alu_b_rd : (free_a ? rd_q[h1] : first_rd);
    assign wd_b_d = b_eff ? alu_b_data : (free_a ? data_q[h1] : first_data);

    assign ld_ready = count_q < CW'(DEPTH);
    assign enq = ld_valid && ld_ready && ld_rd != '0
              && !(a_eff && ld_rd == alu_a_rd) && !(b_eff && ld_rd == alu_b_rd);
    assign count_d = count_q + CW'(enq) - CW'(pop0) - CW'(pop1);
    assign head_d  = head_q + PW'(pop0) + PW'(pop1);
    assign tail_d  = tail_q + PW'(enq);

    always_comb begin
        live_d = live_k;
        if (pop0) live_d[head_q] = 1'b0;
        if (pop1) live_d[h1] = 1'b0;
        if (enq) live_d[tail_q] = 1'b1;
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live_q[i]) pending[rd_q[i]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[tail_q]   <= ld_rd;
            data_q[tail_q] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wea_q   <= 1'b0;
            web_q   <= 1'b0;
            wa_a_q  <= '0;
            wa_b_q  <= '0;
            wd_a_q  <= '0;
            wd_b_q  <= '0;
        end else begin
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wea_q   <= wea_d;
            web_q   <= web_d;
            wa_a_q  <= wa_a_d;
            wa_b_q  <= wa_b_d;
            wd_a_q  <= wd_a_d;
            wd_b_q  <= wd_b_d;
        end
    end

    assign WEA        = wea_q;
    assign waA        = wa_a_q;
    assign WD3        = wd_a_q;
    assign WEB        = web_q;
    assign waB        = wa_b_q;
    assign WD6        = wd_b_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: directed and random stimulus against a queue-based model of the write-back scheduler.
module tb_wb_scheduler;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_a_valid = 1'b0, alu_b_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_a_rd = '0, alu_b_rd = '0, ld_rd = '0;
    logic [31:0] alu_a_data = '0, alu_b_data = '0, ld_data = '0;
    logic        ld_ready, WEA, WEB;
    logic [4:0]  waA, waB;
    logic [31:0] WD3, WD6, pending;
    logic [2:0]  fifo_count;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    wb_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_a_valid(alu_a_valid), .alu_a_rd(alu_a_rd), .alu_a_data(alu_a_data),
        .alu_b_valid(alu_b_valid), .alu_b_rd(alu_b_rd), .alu_b_data(alu_b_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .waA(waA), .WD3(WD3), .WEA(WEA), .waB(waB), .WD6(WD6), .WEB(WEB),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    // one clock of stimulus; model predicts what the ports show after the edge
    task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit bv, input logic [4:0] br, input logic [31:0] bd,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ldd);
        bit ae, be, au, rdy, ea, eb;
        int nf;
        ent_t w[$];
        logic [4:0]  ra = '0, rb = '0;
        logic [31:0] da = '0, db = '0;
        alu_a_valid = av; alu_a_rd = ar; alu_a_data = ad;
        alu_b_valid = bv; alu_b_rd = br; alu_b_data = bd;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        rdy = q.size() < DEPTH;
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, rdy});
        ae = av && ar != 0;
        be = bv && br != 0;
        au = ae && !(be && ar == br);
        foreach (q[i]) if ((ae && q[i].rd == ar) || (be && q[i].rd == br)) q[i].live = 1'b0;
        nf = (au ? 0 : 1) + (be ? 0 : 1);
        for (int k = 0; k < 2; k++) begin
            if (q.size() == 0) break;
            if (q[0].live) begin
                if (nf == 0) break;
                nf--;
                w.push_back(q[0]);
            end
            void'(q.pop_front());
        end
        if (w.size() == 2 && w[0].rd == w[1].rd) void'(w.pop_front());
        ea = au; ra = ar; da = ad;
        eb = be; rb = br; db = bd;
        if (!au && w.size() > 0) begin
            ea = 1'b1; ra = w[0].rd; da = w[0].data;
            void'(w.pop_front());
        end
        if (!be && w.size() > 0) begin
            eb = 1'b1; rb = w[0].rd; db = w[0].data;
        end
        if (lv && rdy && lr != 0 && !(ae && lr == ar) && !(be && lr == br))
            q.push_back('{lr, ldd, 1'b1});
        @(posedge clk);
        #1;
        chk("WEA", {31'b0, WEA}, {31'b0, ea});
        chk("WEB", {31'b0, WEB}, {31'b0, eb});
        if (ea) begin
            chk("waA", {27'b0, waA}, {27'b0, ra});
            chk("WD3", WD3, da);
        end
        if (eb) begin
            chk("waB", {27'b0, waB}, {27'b0, rb});
            chk("WD6", WD6, db);
        end
        chk("fifo_count", {29'b0, fifo_count}, q.size());
        chk("pending", pending, model_pending());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_WEA", {31'b0, WEA}, 0);
        chk("rst_WEB", {31'b0, WEB}, 0);
        chk("rst_waA", {27'b0, waA}, 0);
        chk("rst_WD6", WD6, 0);
        chk("rst_count", {29'b0, fifo_count}, 0);
        chk("rst_pending", pending, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_ld_ready", {31'b0, ld_ready}, 1);
        // single lane A write
        step(1, 5, 32'h11, 0, 0, 0, 0, 0, 0);
        chk("t1_waA", {27'b0, waA}, 5);
        // both lanes to x7: lane B wins
        step(1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 0);
        chk("t2_WEA", {31'b0, WEA}, 0);
        chk("t2_WD6", WD6, 32'hBB);
        // fill FIFO while lanes busy, then drain two per cycle
        for (int i = 1; i <= 5; i++) step(1, 20, i, 1, 21, i, 1, 5'(i), 32'h100 + i);
        chk("t3_full", {29'b0, fifo_count}, 4);
        chk("t3_pending", pending, 32'h1E);
        chk("t3_ready", {31'b0, ld_ready}, 0);
        idle(3);
        chk("t3_empty", pending, 0);
        // queued load to x9 killed by a later ALU write
        step(1, 20, 1, 1, 21, 2, 1, 9, 32'hDEAD);
        chk("t4_pend9", {31'b0, pending[9]}, 1);
        step(1, 9, 32'h55, 1, 21, 3, 0, 0, 0);
        chk("t4_WD3", WD3, 32'h55);
        idle(2);
        // register 0 filtering
        step(1, 0, 1, 1, 0, 2, 1, 0, 3);
        chk("t5_count", {29'b0, fifo_count}, 0);
        // asynchronous reset with traffic in flight
        for (int i = 1; i <= 3; i++) step(1, 10, i, 1, 11, i, 1, 5'(i), i);
        chk("t6_pre_WEA", {31'b0, WEA}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_WEA", {31'b0, WEA}, 0);
        chk("t6_count", {29'b0, fifo_count}, 0);
        chk("t6_pending", pending, 0);
        q.delete();
        alu_a_valid = 0; alu_b_valid = 0; ld_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // random traffic alternating busy and idle lane phases
        for (int c = 0; c < 2000; c++) begin
            int busy;
            busy = ((c / 100) % 2) ? 80 : 20;
            step($urandom_range(99) < busy, 5'($urandom_range(7)), $urandom,
                 $urandom_range(99) < busy, 5'($urandom_range(7)), $urandom,
                 $urandom_range(99) < 60, 5'($urandom_range(7)), $urandom);
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
